mem_port_arbiter: RTL and testbench

- Shares the single memory port (6-bit address, 16-bit data, one write strobe, one read strobe) between two requesters: the processor datapath (CPU) and a DMA/loader port used for program load and debug inspection.
- Sits between the CPU top level and the memory block. It replaces the direct datapath-to-memory wiring with one arbitrated path.
- Each access uses a registered request/acknowledge handshake. CPU has fixed priority, with a starvation limit that protects the DMA port.

---
 rtl/mem_port_arbiter_pkg.sv | 7 +
 rtl/mem_port_grant.sv | 18 +
 rtl/mem_port_arbiter.sv | 107 ++++++++++
 tb/tb_mem_port_arbiter.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared encodings and default widths for the memory port arbiter
package mem_port_arbiter_pkg;
  localparam int ADDR_W_DEF = 6;
  localparam int DATA_W_DEF = 16;
  typedef enum logic [1:0] {OWN_NONE = 2'b00, OWN_CPU = 2'b01, OWN_DMA = 2'b10} owner_e;
  typedef enum logic [1:0] {IDLE, ACC_CPU, ACC_DMA, RESP} state_e;
endpackage

// File: rtl/mem_port_grant.sv
// mem_port_grant: fixed CPU priority, yielding to DMA once the hold limit is reached
module mem_port_grant
  import mem_port_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 4
) (
  input  logic       cpu_req,
  input  logic       dma_req,
  input  logic [3:0] hold_cnt,
  output owner_e     next_owner
);
  logic starve;
  // DMA wins a tie only after MAX_HOLD consecutive CPU grants
  always_comb begin
    starve = dma_req && (hold_cnt == 4'(MAX_HOLD));
    next_owner = (cpu_req && !starve) ? OWN_CPU : dma_req ? OWN_DMA : OWN_NONE;
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between CPU and DMA with a req/ack handshake
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int MAX_HOLD = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_ack,
  output logic [DATA_W-1:0] dma_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_write,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        owner
);
  state_e            state_q, state_d;
  owner_e            owner_q, owner_d, next_owner;
  logic [3:0]        hold_q, hold_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, cpu_rdata_q, cpu_rdata_d, dma_rdata_q, dma_rdata_d;

  mem_port_grant #(.MAX_HOLD(MAX_HOLD)) u_grant (
    .cpu_req   (cpu_req),
    .dma_req   (dma_req),
    .hold_cnt  (hold_q),
    .next_owner(next_owner)
  );

  // Address/data are latched at grant so they persist after the access ends
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    hold_d      = hold_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    dma_rdata_d = dma_rdata_q;
    case (state_q)
      ACC_CPU: begin
        state_d     = RESP;
        cpu_rdata_d = cpu_we ? cpu_rdata_q : mem_rdata;
      end
      ACC_DMA: begin
        state_d     = RESP;
        dma_rdata_d = dma_we ? dma_rdata_q : mem_rdata;
      end
      IDLE, RESP: begin
        owner_d = next_owner;
        state_d = next_owner == OWN_CPU ? ACC_CPU : next_owner == OWN_DMA ? ACC_DMA : IDLE;
        if (next_owner == OWN_CPU) begin
          addr_d  = cpu_addr;
          wdata_d = cpu_wdata;
          hold_d  = !dma_req ? 4'd0 : (hold_q == 4'(MAX_HOLD)) ? hold_q : hold_q + 4'd1;
        end else if (next_owner == OWN_DMA) begin
          addr_d  = dma_addr;
          wdata_d = dma_wdata;
          hold_d  = 4'd0;
        end
      end
    endcase
  end

  // State register; reset abandons any access in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      owner_q     <= OWN_NONE;
      hold_q      <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      hold_q      <= hold_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      dma_rdata_q <= dma_rdata_d;
    end
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_write = (state_q == ACC_CPU && cpu_we) || (state_q == ACC_DMA && dma_we);
  assign mem_read  = (state_q == ACC_CPU && !cpu_we) || (state_q == ACC_DMA && !dma_we);
  assign cpu_ack   = state_q == RESP && owner_q == OWN_CPU;
  assign dma_ack   = state_q == RESP && owner_q == OWN_DMA;
  assign cpu_rdata = cpu_rdata_q;
  assign dma_rdata = dma_rdata_q;
  assign owner     = owner_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of arbitration, latency, starvation and reset
module tb_mem_port_arbiter;
  logic        clk = 0, rst_n = 0;
  logic        cpu_req = 0, cpu_we = 0, dma_req = 0, dma_we = 0;
  logic [5:0]  cpu_addr = 0, dma_addr = 0, mem_addr;
  logic [15:0] cpu_wdata = 0, dma_wdata = 0, cpu_rdata, dma_rdata, mem_wdata, mem_rdata;
  logic        cpu_ack, dma_ack, mem_write, mem_read;
  logic [1:0]  owner;
  logic [15:0] mem [64];
  int          tests = 0, fails = 0, wr_cnt = 0;

  mem_port_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_ack(dma_ack), .dma_rdata(dma_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write), .mem_read(mem_read),
    .mem_rdata(mem_rdata), .owner(owner)
  );

  always #5 clk = ~clk;
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) if (mem_write) begin
    mem[mem_addr] <= mem_wdata;
    wr_cnt <= wr_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic acc(input bit d, input logic we, input logic [5:0] a, input logic [15:0] wd, input logic [15:0] exp);
    int n;
    bit got;
    @(negedge clk);
    if (d) begin dma_req = 1; dma_we = we; dma_addr = a; dma_wdata = wd; end
    else begin cpu_req = 1; cpu_we = we; cpu_addr = a; cpu_wdata = wd; end
    n = 0;
    got = 0;
    while (!got && n < 8) begin
      @(negedge clk);
      n++;
      got = d ? dma_ack : cpu_ack;
      if (n == 1) check("own_acc", owner, d ? 2'b10 : 2'b01);
    end
    check("latency", n, 2);
    check("own_resp", owner, d ? 2'b10 : 2'b01);
    if (!we) check("rdata", d ? dma_rdata : cpu_rdata, exp);
    cpu_req = 0;
    dma_req = 0;
  endtask

  initial begin
    int cyc, cpu_n, cpu_pre, dma_cyc, cpu_cyc2, base;
    for (int i = 0; i < 64; i++) mem[i] = 16'h1000 + 16'(i);
    repeat (2) @(negedge clk);
    check("rst_owner", owner, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_rdata", {cpu_rdata, dma_rdata}, 0);
    check("rst_ack", {cpu_ack, dma_ack, mem_write, mem_read}, 0);
    rst_n = 1;
    @(negedge clk);
    cpu_req = 1; cpu_we = 1; cpu_addr = 6'h05; cpu_wdata = 16'hBEEF;
    @(posedge clk);
    #2;
    check("pre_rst_wr", mem_write, 1);
    rst_n = 0;
    #1;
    check("rst_wr_drop", mem_write, 0);
    check("rst_no_ack", cpu_ack, 0);
    check("rst_owner2", owner, 0);
    cpu_req = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    acc(0, 0, 6'h05, 0, 16'h1005);
    acc(0, 1, 6'h0A, 16'h1234, 0);
    acc(0, 0, 6'h0A, 0, 16'h1234);
    acc(1, 1, 6'h3F, 16'hA5A5, 0);
    acc(1, 0, 6'h3F, 0, 16'hA5A5);
    check("cpu_rd_keep", cpu_rdata, 16'h1234);
    // simultaneous: CPU write 0x10, DMA read 0x0A
    @(negedge clk);
    cpu_req = 1; cpu_we = 1; cpu_addr = 6'h10; cpu_wdata = 16'h1111;
    dma_req = 1; dma_we = 0; dma_addr = 6'h0A;
    cpu_cyc2 = 0; dma_cyc = 0;
    for (cyc = 1; cyc <= 10 && dma_cyc == 0; cyc++) begin
      @(negedge clk);
      if (cyc == 1) check("sim_own1", owner, 2'b01);
      if (cyc == 3) check("sim_own3", owner, 2'b10);
      if (cpu_ack) begin cpu_cyc2 = cyc; cpu_req = 0; end
      if (dma_ack) begin dma_cyc = cyc; dma_req = 0; end
    end
    check("sim_cpu_ack", cpu_cyc2, 2);
    check("sim_dma_ack", dma_cyc, 4);
    check("sim_dma_rd", dma_rdata, 16'h1234);
    acc(0, 0, 6'h10, 0, 16'h1111);
    // starvation: CPU reads 0x0A continuously, DMA reads 0x3F waits
    @(negedge clk);
    cpu_req = 1; cpu_we = 0; cpu_addr = 6'h0A;
    dma_req = 1; dma_we = 0; dma_addr = 6'h3F;
    cpu_n = 0; cpu_pre = -1; dma_cyc = 0; cpu_cyc2 = 0;
    for (cyc = 1; cyc <= 30 && cpu_cyc2 == 0; cyc++) begin
      @(negedge clk);
      if (cpu_ack) begin
        cpu_n++;
        if (dma_cyc != 0) begin cpu_cyc2 = cyc; cpu_req = 0; end
      end
      if (dma_ack) begin dma_cyc = cyc; cpu_pre = cpu_n; dma_req = 0; end
    end
    check("starv_cpu_n", cpu_pre, 4);
    check("starv_dma_cyc", dma_cyc, 10);
    check("starv_resume", cpu_cyc2, 12);
    check("starv_dma_rd", dma_rdata, 16'hA5A5);
    // back-to-back DMA writes 0x20 then 0x21
    @(negedge clk);
    base = wr_cnt;
    dma_req = 1; dma_we = 1; dma_addr = 6'h20; dma_wdata = 16'h0A0A;
    cyc = 0;
    while (!dma_ack && cyc < 8) begin @(negedge clk); cyc++; end
    check("b2b_ack1", cyc, 2);
    dma_addr = 6'h21; dma_wdata = 16'h0B0B;
    @(negedge clk);
    check("b2b_no_gap", {owner, mem_write, mem_addr}, {2'b10, 1'b1, 6'h21});
    @(negedge clk);
    check("b2b_ack2", dma_ack, 1);
    dma_req = 0;
    @(negedge clk);
    check("b2b_wr_cnt", wr_cnt - base, 2);
    acc(1, 0, 6'h20, 0, 16'h0A0A);
    acc(1, 0, 6'h21, 0, 16'h0B0B);
    check("b2b_cpu_keep", cpu_rdata, 16'h1234);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
